lpif_asym2_half_slave_rx_sync: RTL and testbench

- Slave-end receive synchroniser for the x16 asym2 half-rate LPIF link, counterpart of the master-side auto-sync marker/strobe generator.
- Watches the strobe and marker userbits recovered from the rx PHY words.
- Qualifies the link with a holdoff plus a strobe-spacing lock check, then drives the rx_online_delay that gates the slave's upstream data path.
- Detects loss of strobe alignment and drops the link.

---
 rtl/lpif_asym2_half_slave_rx_sync.sv | 204 ++++++++++++++++++++
 tb/tb_lpif_asym2_half_slave_rx_sync.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lpif_asym2_half_slave_rx_sync.sv
// ---------------------------------------------------------------------------
// lpif_asym2_half_slave_rx_sync
//
// Slave-end receive synchroniser for the x16 asym2 half-rate LPIF link.
// It watches the strobe and marker userbits recovered from the rx PHY words.
// The link is qualified by a holdoff followed by a strobe-spacing lock check.
// Once locked, it raises rx_online_delay, which gates the upstream data path.
// Loss of strobe alignment drops the link back to hunting.
//
// Ports:
//   clk_wr           in   single clock
//   rst_wr_n         in   asynchronous active-low reset
//   rx_online        in   PHY receive path ready
//   rx_stb_userbit   in   strobe bit from rx PHY word
//   rx_mrk_userbit   in   marker bits from rx PHY word (MARKER_WIDTH)
//   delay_x_value    in   holdoff cycles after rx_online rises (16)
//   stb_period       in   expected strobe spacing, 0 treated as 1 (8)
//   rx_online_delay  out  qualified link-up (rx_locked & rx_online)
//   rx_locked        out  strobe lock achieved (state RUN)
//   stb_err_count    out  saturating count of violations seen in RUN (8)
//   debug_status     out  {state[2:0], rx_locked, stb_err_count, 20'b0}
// ---------------------------------------------------------------------------
module lpif_asym2_half_slave_rx_sync #(
  parameter int MARKER_WIDTH = 2,
  parameter int LOCK_COUNT   = 4,
  parameter int LOSS_COUNT   = 2
) (
  input  logic                    clk_wr,
  input  logic                    rst_wr_n,
  input  logic                    rx_online,
  input  logic                    rx_stb_userbit,
  input  logic [MARKER_WIDTH-1:0] rx_mrk_userbit,
  input  logic [15:0]             delay_x_value,
  input  logic [7:0]              stb_period,
  output logic                    rx_online_delay,
  output logic                    rx_locked,
  output logic [7:0]              stb_err_count,
  output logic [31:0]             debug_status
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLDOFF = 3'd1,
    ST_HUNT    = 3'd2,
    ST_LOCK    = 3'd3,
    ST_RUN     = 3'd4
  } state_t;

  // Valid marker: MSB set, every other bit clear.
  localparam logic [MARKER_WIDTH-1:0] MRK_EXP = MARKER_WIDTH'(1) << (MARKER_WIDTH - 1);
  localparam logic [7:0] LOCK_CNT8 = 8'(LOCK_COUNT);
  localparam logic [7:0] LOSS_CNT8 = 8'(LOSS_COUNT);

  state_t      r_state;
  logic [15:0] r_hold_cnt;
  logic [8:0]  r_interval;
  logic [7:0]  r_good;
  logic [7:0]  r_bad;
  logic [7:0]  r_err_cnt;
  logic        r_locked;

  state_t      w_state_next;
  logic [15:0] w_hold_next;
  logic [8:0]  w_interval_next;
  logic [7:0]  w_good_next;
  logic [7:0]  w_bad_next;
  logic [7:0]  w_err_next;

  logic [8:0]  w_period;
  logic        w_mrk_ok;
  logic        w_good_stb;
  logic        w_violation;
  logic [7:0]  w_good_inc;
  logic [7:0]  w_bad_inc;
  logic [7:0]  w_err_sat;

  // Interval is one bit wider than the period, so a missing strobe at
  // P=255 is seen at interval 256 instead of wrapping.
  assign w_period    = (stb_period == 8'd0) ? 9'd1 : {1'b0, stb_period};
  assign w_mrk_ok    = (rx_mrk_userbit == MRK_EXP);
  assign w_good_stb  = rx_stb_userbit && (r_interval == w_period) && w_mrk_ok;
  // A strobe that is mistimed or carries a bad marker, or an overdue strobe.
  // The overdue case is flagged once interval has actually reached P+1.
  assign w_violation = (rx_stb_userbit && !((r_interval == w_period) && w_mrk_ok)) ||
                       (!rx_stb_userbit && (r_interval > w_period));
  assign w_good_inc  = r_good + 8'd1;
  assign w_bad_inc   = r_bad + 8'd1;
  assign w_err_sat   = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;

  always_comb begin
    w_state_next    = r_state;
    w_hold_next     = r_hold_cnt;
    w_interval_next = r_interval;
    w_good_next     = r_good;
    w_bad_next      = r_bad;
    w_err_next      = r_err_cnt;

    if (!rx_online) begin
      // The error count is deliberately kept across link drops.
      w_state_next    = ST_IDLE;
      w_hold_next     = 16'd0;
      w_interval_next = 9'd0;
      w_good_next     = 8'd0;
      w_bad_next      = 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = ST_HOLDOFF;
          w_hold_next  = delay_x_value;
        end

        ST_HOLDOFF: begin
          // A zero count leaves on the first HOLDOFF cycle.
          if (r_hold_cnt == 16'd0) begin
            w_state_next = ST_HUNT;
          end else begin
            w_hold_next = r_hold_cnt - 16'd1;
          end
        end

        ST_HUNT: begin
          if (rx_stb_userbit) begin
            w_interval_next = 9'd1;
            w_good_next     = 8'd1;
            w_bad_next      = 8'd0;
            w_state_next    = (LOCK_COUNT == 1) ? ST_RUN : ST_LOCK;
          end
        end

        ST_LOCK: begin
          if (w_good_stb) begin
            w_interval_next = 9'd1;
            w_good_next     = w_good_inc;
            if (w_good_inc >= LOCK_CNT8) begin
              w_state_next = ST_RUN;
              w_bad_next   = 8'd0;
            end
          end else if (w_violation) begin
            // The violating strobe is consumed here; HUNT waits for a new one.
            w_state_next    = ST_HUNT;
            w_good_next     = 8'd0;
            w_interval_next = 9'd0;
          end else begin
            w_interval_next = r_interval + 9'd1;
          end
        end

        ST_RUN: begin
          if (w_good_stb) begin
            w_bad_next      = 8'd0;
            w_interval_next = 9'd1;
          end else if (w_violation) begin
            w_interval_next = 9'd1;
            w_err_next      = w_err_sat;
            if (w_bad_inc >= LOSS_CNT8) begin
              w_state_next = ST_HUNT;
              w_good_next  = 8'd0;
              w_bad_next   = 8'd0;
            end else begin
              w_bad_next = w_bad_inc;
            end
          end else begin
            w_interval_next = r_interval + 9'd1;
          end
        end

        default: begin
          w_state_next    = ST_IDLE;
          w_hold_next     = 16'd0;
          w_interval_next = 9'd0;
          w_good_next     = 8'd0;
          w_bad_next      = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= 16'd0;
      r_interval <= 9'd0;
      r_good     <= 8'd0;
      r_bad      <= 8'd0;
      r_err_cnt  <= 8'd0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
      r_interval <= w_interval_next;
      r_good     <= w_good_next;
      r_bad      <= w_bad_next;
      r_err_cnt  <= w_err_next;
      r_locked   <= (w_state_next == ST_RUN);
    end
  end

  // Combinational AND so the upstream path closes in the same cycle rx_online drops.
  assign rx_online_delay = r_locked & rx_online;
  assign rx_locked       = r_locked;
  assign stb_err_count   = r_err_cnt;
  assign debug_status    = {r_state, r_locked, r_err_cnt, 20'd0};

endmodule

// File: tb/tb_lpif_asym2_half_slave_rx_sync.sv
module tb_lpif_asym2_half_slave_rx_sync;

  logic        clk_wr;
  logic        rst_wr_n;
  logic        rx_online;
  logic        rx_stb_userbit;
  logic [1:0]  rx_mrk_userbit;
  logic [15:0] delay_x_value;
  logic [7:0]  stb_period;
  logic        rx_online_delay;
  logic        rx_locked;
  logic [7:0]  stb_err_count;
  logic [31:0] debug_status;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] MOK  = 2'b10;
  localparam logic [1:0] MBAD = 2'b01;

  lpif_asym2_half_slave_rx_sync #(
    .MARKER_WIDTH(2),
    .LOCK_COUNT(4),
    .LOSS_COUNT(2)
  ) dut (
    .clk_wr(clk_wr),
    .rst_wr_n(rst_wr_n),
    .rx_online(rx_online),
    .rx_stb_userbit(rx_stb_userbit),
    .rx_mrk_userbit(rx_mrk_userbit),
    .delay_x_value(delay_x_value),
    .stb_period(stb_period),
    .rx_online_delay(rx_online_delay),
    .rx_locked(rx_locked),
    .stb_err_count(stb_err_count),
    .debug_status(debug_status)
  );

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given strobe/marker; outputs are stable on return.
  task automatic tick(input logic stb, input logic [1:0] mrk);
    rx_stb_userbit = stb;
    rx_mrk_userbit = mrk;
    @(posedge clk_wr);
    #1;
    rx_stb_userbit = 1'b0;
    rx_mrk_userbit = 2'b00;
  endtask

  // P-1 empty cycles then one strobe cycle.
  task automatic blk(input int p, input logic [1:0] mrk);
    repeat (p - 1) tick(1'b0, 2'b00);
    tick(1'b1, mrk);
  endtask

  task automatic note(input string s);
    $display("step %-28s state=%0d locked=%0b online_dly=%0b err=%0d",
             s, debug_status[31:29], rx_locked, rx_online_delay, stb_err_count);
  endtask

  initial begin
    rst_wr_n       = 1'b0;
    rx_online      = 1'b0;
    rx_stb_userbit = 1'b0;
    rx_mrk_userbit = 2'b00;
    delay_x_value  = 16'd3;
    stb_period     = 8'd4;

    // Reset state
    repeat (3) @(posedge clk_wr);
    #1;
    chk("reset_locked", {31'd0, rx_locked}, 32'd0);
    chk("reset_err", {24'd0, stb_err_count}, 32'd0);
    chk("reset_debug", debug_status, 32'd0);
    chk("reset_online_dly", {31'd0, rx_online_delay}, 32'd0);
    rst_wr_n = 1'b1;
    tick(1'b0, 2'b00);
    note("reset released");

    // Lock up: holdoff of delay+1 = 4 cycles, then HUNT
    rx_online = 1'b1;
    tick(1'b0, 2'b00);
    chk("holdoff_0", {29'd0, debug_status[31:29]}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick(1'b0, 2'b00);
      chk($sformatf("holdoff_%0d", i), {29'd0, debug_status[31:29]}, 32'd1);
    end
    tick(1'b0, 2'b00);
    chk("hunt_after_holdoff", {29'd0, debug_status[31:29]}, 32'd2);
    tick(1'b1, MOK);
    chk("lock_on_first_stb", {29'd0, debug_status[31:29]}, 32'd3);
    blk(4, MOK);
    blk(4, MOK);
    chk("not_locked_after_3", {31'd0, rx_locked}, 32'd0);
    blk(4, MOK);
    chk("locked_after_4", {31'd0, rx_locked}, 32'd1);
    chk("run_state", {29'd0, debug_status[31:29]}, 32'd4);
    chk("online_dly_up", {31'd0, rx_online_delay}, 32'd1);
    note("locked");

    // Marker fault in RUN: one error, lock retained
    blk(4, MOK);
    blk(4, MBAD);
    chk("mrk_fault_err", {24'd0, stb_err_count}, 32'd1);
    chk("mrk_fault_locked", {31'd0, rx_locked}, 32'd1);
    blk(4, MOK);
    chk("mrk_recover_state", {29'd0, debug_status[31:29]}, 32'd4);
    note("marker fault");

    // Single miss (flagged at interval 5), then a good strobe
    repeat (5) tick(1'b0, 2'b00);
    chk("miss1_err", {24'd0, stb_err_count}, 32'd2);
    chk("miss1_locked", {31'd0, rx_locked}, 32'd1);
    blk(4, MOK);
    chk("miss1_recover_err", {24'd0, stb_err_count}, 32'd2);
    chk("miss1_recover_locked", {31'd0, rx_locked}, 32'd1);
    note("single miss");

    // Two consecutive misses: loss of lock
    repeat (5) tick(1'b0, 2'b00);
    chk("loss_first_err", {24'd0, stb_err_count}, 32'd3);
    repeat (4) tick(1'b0, 2'b00);
    chk("loss_still_locked", {31'd0, rx_locked}, 32'd1);
    tick(1'b0, 2'b00);
    chk("loss_err", {24'd0, stb_err_count}, 32'd4);
    chk("loss_locked", {31'd0, rx_locked}, 32'd0);
    chk("loss_state_hunt", {29'd0, debug_status[31:29]}, 32'd2);
    chk("loss_online_dly", {31'd0, rx_online_delay}, 32'd0);
    note("loss");

    // Early strobe in LOCK: back to HUNT, no error counted
    tick(1'b1, MOK);
    blk(4, MOK);
    chk("early_pre_state", {29'd0, debug_status[31:29]}, 32'd3);
    blk(3, MOK);
    chk("early_state_hunt", {29'd0, debug_status[31:29]}, 32'd2);
    chk("early_locked", {31'd0, rx_locked}, 32'd0);
    chk("early_err_held", {24'd0, stb_err_count}, 32'd4);
    // The violating strobe is not reused: a full fresh acquisition is needed
    tick(1'b1, MOK);
    blk(4, MOK);
    blk(4, MOK);
    chk("relock_not_yet", {31'd0, rx_locked}, 32'd0);
    blk(4, MOK);
    chk("relock_locked", {31'd0, rx_locked}, 32'd1);
    chk("relock_debug", debug_status, {3'd4, 1'b1, 8'd4, 20'd0});
    note("early strobe + relock");

    // rx_online drop for one cycle
    rx_online = 1'b0;
    #1;
    chk("drop_online_dly_now", {31'd0, rx_online_delay}, 32'd0);
    chk("drop_locked_reg", {31'd0, rx_locked}, 32'd1);
    @(posedge clk_wr);
    #1;
    chk("drop_state_idle", {29'd0, debug_status[31:29]}, 32'd0);
    chk("drop_locked", {31'd0, rx_locked}, 32'd0);
    chk("drop_err_held", {24'd0, stb_err_count}, 32'd4);
    // Restart with zero holdoff: exactly one HOLDOFF cycle
    delay_x_value = 16'd0;
    rx_online = 1'b1;
    tick(1'b0, 2'b00);
    chk("restart_holdoff", {29'd0, debug_status[31:29]}, 32'd1);
    tick(1'b0, 2'b00);
    chk("restart_hunt", {29'd0, debug_status[31:29]}, 32'd2);
    note("online drop + restart");

    // stb_period=0 acts as 1: strobe every cycle locks after 4 strobes
    stb_period = 8'd0;
    repeat (3) tick(1'b1, MOK);
    chk("p0_lock_state", {29'd0, debug_status[31:29]}, 32'd3);
    chk("p0_not_locked", {31'd0, rx_locked}, 32'd0);
    tick(1'b1, MOK);
    chk("p0_locked", {31'd0, rx_locked}, 32'd1);
    note("period 0 lock");

    // Saturation: alternate bad-marker and good strobes
    repeat (100) begin
      tick(1'b1, MBAD);
      tick(1'b1, MOK);
    end
    chk("sat_mid_err", {24'd0, stb_err_count}, 32'd104);
    chk("sat_mid_locked", {31'd0, rx_locked}, 32'd1);
    repeat (200) begin
      tick(1'b1, MBAD);
      tick(1'b1, MOK);
    end
    chk("sat_err", {24'd0, stb_err_count}, 32'd255);
    chk("sat_locked", {31'd0, rx_locked}, 32'd1);
    note("saturation");

    // Asynchronous reset mid-RUN: outputs clear without a clock edge
    rst_wr_n = 1'b0;
    #1;
    chk("areset_locked", {31'd0, rx_locked}, 32'd0);
    chk("areset_err", {24'd0, stb_err_count}, 32'd0);
    chk("areset_debug", debug_status, 32'd0);
    chk("areset_online_dly", {31'd0, rx_online_delay}, 32'd0);
    note("async reset");
    repeat (2) @(posedge clk_wr);
    #1;
    rst_wr_n = 1'b1;
    tick(1'b0, 2'b00);
    chk("post_reset_holdoff", {29'd0, debug_status[31:29]}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
